// File: rtl/mtr_duty_seq.sv
// Duty-command sequencer: slews left/right duties toward captured targets with a zero dwell on
// reversals. Optional macro MTR_DUTY_LIMIT_EN clamps captured targets to +/-MAX_DUTY.
module mtr_duty_seq #(
  parameter int unsigned TICK_DIV    = 1024,
  parameter int unsigned STEP        = 16,
  parameter int unsigned DWELL_TICKS = 8,
  parameter int unsigned MAX_DUTY    = 2047
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tgt_vld,
  input  logic signed [11:0] lft_tgt,
  input  logic signed [11:0] rght_tgt,
  output logic signed [11:0] lft_duty,
  output logic signed [11:0] rght_duty,
  output logic               settled
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DwW  = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;
  localparam logic signed [12:0] Step13 = 13'(STEP);
  localparam logic [CntW-1:0]    CntMax = CntW'(TICK_DIV - 1);
  localparam logic [DwW-1:0]     DwInit = DwW'(DWELL_TICKS);

  typedef enum logic {StRun, StDwell} ch_st_e;

  logic [CntW-1:0]    cnt_q;
  logic               tick;
  logic signed [11:0] tgt_q [2];
  logic signed [11:0] cur_q [2];
  ch_st_e             st_q  [2];
  logic [DwW-1:0]     dw_q  [2];
  logic               settled_q;

  logic signed [11:0] tgt_in   [2];
  logic signed [11:0] tgt_cap  [2];
  logic signed [12:0] cur13    [2];
  logic signed [12:0] tgt13    [2];
  logic signed [12:0] diff13   [2];
  logic signed [12:0] ramp13   [2];
  logic signed [12:0] rev13    [2];
  logic               reversal [2];

  assign tgt_in[0] = lft_tgt;
  assign tgt_in[1] = rght_tgt;
  assign tick      = en && (cnt_q == CntMax);

`ifdef MTR_DUTY_LIMIT_EN
  function automatic logic signed [11:0] lim_tgt(input logic signed [11:0] t);
    logic signed [12:0] t13;
    logic signed [12:0] pos;
    logic signed [12:0] neg;
    t13 = t;
    pos = 13'(MAX_DUTY);
    neg = -pos;
    if (t13 > pos) begin
      return pos[11:0];
    end else if (t13 < neg) begin
      return neg[11:0];
    end
    return t;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tgt_cap[i] = lim_tgt(tgt_in[i]);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tgt_cap[i] = tgt_in[i];
    end
  end
`endif

  // 13-bit signed step arithmetic so differences across the full range never wrap.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cur13[i]  = cur_q[i];
      tgt13[i]  = tgt_q[i];
      diff13[i] = tgt13[i] - cur13[i];
      if ((diff13[i] <= Step13) && (diff13[i] >= -Step13)) begin
        ramp13[i] = tgt13[i];
      end else if (diff13[i] > 13'sd0) begin
        ramp13[i] = cur13[i] + Step13;
      end else begin
        ramp13[i] = cur13[i] - Step13;
      end
      if (!cur_q[i][11]) begin
        rev13[i] = (cur13[i] <= Step13) ? 13'sd0 : cur13[i] - Step13;
      end else begin
        rev13[i] = (cur13[i] >= -Step13) ? 13'sd0 : cur13[i] + Step13;
      end
      reversal[i] = (cur_q[i] != 12'sd0) && (tgt_q[i] != 12'sd0) &&
                    (cur_q[i][11] != tgt_q[i][11]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      settled_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
        st_q[i]  <= StRun;
        dw_q[i]  <= '0;
      end
    end else begin
      settled_q <= en && (st_q[0] == StRun) && (st_q[1] == StRun) &&
                   (cur_q[0] == tgt_q[0]) && (cur_q[1] == tgt_q[1]);
      if (tgt_vld) begin
        for (int i = 0; i < 2; i++) begin
          tgt_q[i] <= tgt_cap[i];
        end
      end
      if (!en) begin
        cnt_q <= '0;
        for (int i = 0; i < 2; i++) begin
          cur_q[i] <= '0;
          st_q[i]  <= StRun;
          dw_q[i]  <= '0;
        end
      end else begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          for (int i = 0; i < 2; i++) begin
            unique case (st_q[i])
              StRun: begin
                if (reversal[i]) begin
                  cur_q[i] <= rev13[i][11:0];
                  if ((rev13[i] == 13'sd0) && (DWELL_TICKS > 0)) begin
                    st_q[i] <= StDwell;
                    dw_q[i] <= DwInit;
                  end
                end else begin
                  cur_q[i] <= ramp13[i][11:0];
                end
              end
              StDwell: begin
                cur_q[i] <= '0;
                dw_q[i]  <= dw_q[i] - 1'b1;
                if (dw_q[i] == DwW'(1)) begin
                  st_q[i] <= StRun;
                end
              end
              default: st_q[i] <= StRun;
            endcase
          end
        end
      end
    end
  end

  assign lft_duty  = cur_q[0];
  assign rght_duty = cur_q[1];
  assign settled   = settled_q;

endmodule

// File: tb/tb_mtr_duty_seq.sv
// Scoreboard bench for mtr_duty_seq: an integer reference model predicts every cycle's outputs,
// a monitor pops and compares after each rising edge.
module tb_mtr_duty_seq;
  localparam int TD = 4;
  localparam int ST = 16;
  localparam int DW = 2;
  localparam int MD = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic tgt_vld = 1'b0;
  logic signed [11:0] lft_tgt = '0;
  logic signed [11:0] rght_tgt = '0;
  logic signed [11:0] lft_duty;
  logic signed [11:0] rght_duty;
  logic settled;

  always #5 clk = ~clk;

  mtr_duty_seq #(
    .TICK_DIV    (TD),
    .STEP        (ST),
    .DWELL_TICKS (DW),
    .MAX_DUTY    (MD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tgt_vld   (tgt_vld),
    .lft_tgt   (lft_tgt),
    .rght_tgt  (rght_tgt),
    .lft_duty  (lft_duty),
    .rght_duty (rght_duty),
    .settled   (settled)
  );

  int errors = 0;
  int checks = 0;
  logic [24:0] exp_q[$];

  // Reference state: dwell remaining > 0 means the channel is parked at zero.
  int m_cnt;
  int m_cur[2];
  int m_tgt[2];
  int m_dw[2];
  int m_set;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampt(input int v);
`ifdef MTR_DUTY_LIMIT_EN
    if (v > MD) return MD;
    if (v < -MD) return -MD;
`endif
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic advance(input int i);
    int mag;
    if (m_dw[i] > 0) begin
      m_dw[i]--;
    end else if (m_cur[i] != 0 && m_tgt[i] != 0 && ((m_cur[i] < 0) != (m_tgt[i] < 0))) begin
      mag = iabs(m_cur[i]) - ST;
      if (mag <= 0) begin
        m_cur[i] = 0;
        if (DW > 0) m_dw[i] = DW;
      end else begin
        m_cur[i] = (m_cur[i] < 0) ? -mag : mag;
      end
    end else if (iabs(m_tgt[i] - m_cur[i]) <= ST) begin
      m_cur[i] = m_tgt[i];
    end else begin
      m_cur[i] = m_cur[i] + ((m_tgt[i] > m_cur[i]) ? ST : -ST);
    end
  endtask

  task automatic model_step();
    int ns;
    if (!rst_n) begin
      m_cnt = 0;
      m_set = 0;
      for (int i = 0; i < 2; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0; m_dw[i] = 0;
      end
    end else begin
      ns = (en && m_dw[0] == 0 && m_dw[1] == 0 && m_cur[0] == m_tgt[0] &&
            m_cur[1] == m_tgt[1]) ? 1 : 0;
      if (!en) begin
        m_cnt = 0;
        for (int i = 0; i < 2; i++) begin
          m_cur[i] = 0; m_dw[i] = 0;
        end
      end else if (m_cnt == TD - 1) begin
        m_cnt = 0;
        advance(0);
        advance(1);
      end else begin
        m_cnt++;
      end
      if (tgt_vld) begin
        m_tgt[0] = clampt(int'(lft_tgt));
        m_tgt[1] = clampt(int'(rght_tgt));
      end
      m_set = ns;
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic v, input int lt, input int rt);
    @(negedge clk);
    rst_n = r; en = e; tgt_vld = v;
    lft_tgt = 12'(lt); rght_tgt = 12'(rt);
    model_step();
    exp_q.push_back({12'(m_cur[0]), 12'(m_cur[1]), m_set[0]});
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b1, en, 1'b0, int'(lft_tgt), int'(rght_tgt));
  endtask

  task automatic settle_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic int rtgt();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 4095)) - 2048;
      1: return int'($urandom_range(0, 80)) - 40;
      2: return -2048;
      default: return 2047;
    endcase
  endfunction

  logic [24:0] e_mon;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      chk("lft_duty", int'(lft_duty), int'($signed(e_mon[24:13])));
      chk("rght_duty", int'(rght_duty), int'($signed(e_mon[12:1])));
      chk("settled", int'(settled), int'(e_mon[0]));
    end
  end

  initial begin
    int guard;
    // Reset held with en and target strobes active.
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, k[0], 500, -300);
    settle_edge();
    chk("rst_lft", int'(lft_duty), 0);
    chk("rst_rght", int'(rght_duty), 0);
    chk("rst_settled", int'(settled), 0);
    cyc(1'b1, 1'b1, 1'b0, 500, -300);
    run(7);
    settle_edge();
    chk("post_rst_lft", int'(lft_duty), 0);

    // Ramp up to 100.
    cyc(1'b1, 1'b1, 1'b1, 100, 0);
    run(40);
    settle_edge();
    chk("ramp_lft", int'(lft_duty), 100);
    chk("ramp_settled", int'(settled), 1);

    // Down to 40, then reverse to -40 through the dwell.
    cyc(1'b1, 1'b1, 1'b1, 40, 0);
    run(24);
    cyc(1'b1, 1'b1, 1'b1, -40, 0);
    run(50);
    settle_edge();
    chk("rev_lft", int'(lft_duty), -40);
    chk("rev_rght", int'(rght_duty), 0);

    // Stop mid-ramp.
    cyc(1'b1, 1'b0, 1'b1, 100, 0);
    run(2);
    cyc(1'b1, 1'b1, 1'b0, 100, 0);
    run(11);
    settle_edge();
    chk("midramp_lft", int'(lft_duty), 48);
    cyc(1'b1, 1'b0, 1'b0, 100, 0);
    settle_edge();
    chk("stop_lft", int'(lft_duty), 0);
    chk("stop_settled", int'(settled), 0);
    cyc(1'b1, 1'b1, 1'b0, 100, 0);
    run(40);

    // Full-scale negative target.
    cyc(1'b1, 1'b0, 1'b1, -2048, 0);
    cyc(1'b1, 1'b1, 1'b0, -2048, 0);
    run(530);
    settle_edge();
    chk("extreme_lft", int'(lft_duty), clampt(-2048));

    // Back to 100, then strobe a new target exactly in a tick cycle.
    cyc(1'b1, 1'b1, 1'b1, 100, 0);
    run(620);
    guard = 0;
    while (m_cnt != TD - 1 && guard < 10) begin
      run(1);
      guard++;
    end
    cyc(1'b1, 1'b1, 1'b1, 200, 0);
    settle_edge();
    chk("tick_coincide_lft", int'(lft_duty), 100);
    run(TD);
    settle_edge();
    chk("tick_next_lft", int'(lft_duty), 116);

    // Target change while dwelling.
    cyc(1'b1, 1'b1, 1'b1, -40, 0);
    guard = 0;
    while (m_dw[0] == 0 && guard < 200) begin
      run(1);
      guard++;
    end
    chk("dwell_reached", (m_dw[0] > 0) ? 1 : 0, 1);
    cyc(1'b1, 1'b1, 1'b1, 60, 0);
    run(60);
    settle_edge();
    chk("dwell_retarget_lft", int'(lft_duty), 60);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) != 0),
          ($urandom_range(0, 14) == 0), rtgt(), rtgt());
    end

    run(2);
    settle_edge();
    settle_edge();
    chk("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mtr_duty_seq.md
Name: mtr_duty_seq

Overview:
- Duty-command sequencer in front of the motor driver: accepts signed 12-bit left/right duty targets and slews the applied duties toward them at a fixed rate.
- Forces a zero-duty dwell on every direction reversal so the H-bridge never jumps between signs.
- Outputs feed the driver's lft_duty/rght_duty inputs directly; also provides a global enable/stop and a settled flag for the upper-level controller.

Parameters:
- TICK_DIV, 1024: clocks per ramp tick; must be at least 1.
- STEP, 16: duty LSBs applied per tick; range 1..2047.
- DWELL_TICKS, 8: ticks held at zero on a reversal; 0 means no dwell.
- MAX_DUTY, 2047: magnitude clamp; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  run enable; 0 forces both duties to zero
- tgt_vld  in  1  one-cycle strobe to capture the targets
- lft_tgt  in  12  signed left duty target
- rght_tgt  in  12  signed right duty target
- lft_duty  out  12  signed applied left duty (registered)
- rght_duty  out  12  signed applied right duty (registered)
- settled  out  1  both channels at target, not dwelling, en=1 (registered)

Behaviour:
- Reset and clocking:
  - Single clock domain. Reset is synchronous and active-low, sampled on the clk rising edge.
  - Reset clears lft_duty, rght_duty, the target registers, the tick counter and the dwell counters to 0, sets both channel FSMs to RUN, and sets settled=0.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 while en=1 and wraps to 0.
  - tick is an internal pulse asserted in the cycle where count==TICK_DIV-1.
  - Count is held at 0 while en=0.
- Target capture:
  - When tgt_vld=1, lft_tgt and rght_tgt are registered.
  - Targets are retained through en=0 and are cleared only by reset.
- Channel FSM (two identical instances, one per side), states RUN and DWELL:
  - RUN, on tick with cur==tgt: hold.
  - RUN, on tick with cur!=0, tgt!=0 and sign(cur)!=sign(tgt) (reversal):
    - Step toward 0: cur moves by ±STEP, saturating at 0 with no overshoot.
    - If the step lands exactly on 0 and DWELL_TICKS>0: go to DWELL, dwell count = DWELL_TICKS.
  - RUN, on tick otherwise: if |tgt-cur|<=STEP, cur=tgt; else cur moves by ±STEP toward tgt.
  - DWELL: cur held at 0. On each tick, dwell count decrements; the tick that takes it to 0 moves the FSM to RUN. Stepping resumes on the following tick.
  - Target changes during DWELL are accepted. After the dwell, the channel ramps to the newest target; no second dwell occurs because cur=0.
- Arithmetic:
  - Differences and steps are computed in 13-bit signed to avoid wrap.
  - Results are always within [-2048, 2047]; -2048 is a legal output.
- Timing:
  - Duty updates are registered one clock after the tick cycle.
  - A tgt_vld coinciding with a tick: that tick uses the previous target; the new target takes effect on the next tick.
- en=0:
  - lft_duty and rght_duty go to 0 on the next clock, with no ramp-down.
  - FSMs go to RUN, dwell counters clear, settled=0.
  - On en returning to 1, ramping restarts from 0 at the first tick.
- settled is registered: settled = en & both channels in RUN & lft_duty==lft_tgt & rght_duty==rght_tgt.
- Channels are independent: one may dwell while the other ramps.

Optional Feature:
- Macro: MTR_DUTY_LIMIT_EN.
- Defined: captured targets are clamped to [-MAX_DUTY, +MAX_DUTY] at capture time, so a stored target never exceeds MAX_DUTY in magnitude.
- Undefined: targets are stored unmodified and MAX_DUTY is ignored.

Test Plan:
Bench parameters unless noted: TICK_DIV=4, STEP=16, DWELL_TICKS=2.
1. Reset: hold rst_n=0 with en=1 and tgt_vld pulsing -> lft_duty=rght_duty=0, settled=0. After release, duties stay 0 until a target is captured.
2. Ramp up: lft_tgt=100, en=1 -> lft_duty steps 16,32,48,64,80,96,100, one step every 4 clocks. settled rises the cycle after 100 is reached with rght_tgt=0.
3. Reversal: lft_duty=40, new lft_tgt=-40 -> 24, 8, 0. Holds 0 for 2 ticks. Then -16, -32, -40. rght channel unaffected.
4. Stop mid-ramp: en=0 while lft_duty=48 (target 100) -> lft_duty=0 the next clock, settled=0. en=1 again -> 16, 32, ... toward 100.
5. Extremes: lft_tgt=-2048 from 0 -> reaches exactly -2048 (128 ticks), no wrap to positive. With MTR_DUTY_LIMIT_EN and MAX_DUTY=1500, target -2048 -> settles at -1500.
6. Simultaneous events: tgt_vld with a new target in the tick cycle -> that tick steps toward the old target. Also, a target change during DWELL -> after the dwell, ramps to the newest target with no extra dwell.
